// File: rtl/aes256_dec_fsm.sv
// aes256_dec_fsm: iterative AES-256 block decryptor, one inverse S-box per cycle.
// Bytes are little-endian in the 128-bit words: byte k = word[8k+7:8k],
// arranged as row k%4, column k/4 of the AES state matrix.
//
// Ports:
//   clk               rising-edge clock
//   reset             synchronous active-high reset
//   dec_dataIn        ciphertext, sampled with ctrl_dataIn_dec in IDLE
//   ctrl_dataIn_dec   start request (ignored while busy)
//   ctrl_abort_dec    abort request (only with AES_DEC_ABORT_EN defined)
//   dec_key           round key addressed by dec_keyAddr (combinational source)
//   dec_keyAddr       registered round-key index 14..0
//   dec_dataOut       plaintext, held until the next result
//   ctrl_dataOut_dec  one-cycle pulse, dec_dataOut valid in the same cycle
//   dec_busy          high whenever the FSM is not in IDLE
//
// Optional feature: define AES_DEC_ABORT_EN to add the ctrl_abort_dec input.
module aes256_dec_fsm (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] dec_dataIn,
  input  logic         ctrl_dataIn_dec,
`ifdef AES_DEC_ABORT_EN
  input  logic         ctrl_abort_dec,
`endif
  input  logic [127:0] dec_key,
  output logic [3:0]   dec_keyAddr,
  output logic [127:0] dec_dataOut,
  output logic         ctrl_dataOut_dec,
  output logic         dec_busy
);

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned NCOLS   = 4;
  localparam int unsigned RND_W   = 4;
  localparam int unsigned CNT_W   = 4;

  localparam logic [RND_W-1:0] RND_FIRST = RND_W'(14);
  localparam logic [RND_W-1:0] RND_NEXT  = RND_W'(13);
  localparam logic [RND_W-1:0] RND_LAST  = RND_W'(0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(15);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDRK  = 3'd1,
    INVSHF = 3'd2,
    INVSUB = 3'd3,
    INVMC  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [BLOCK_W-1:0] blk_q;
  logic [RND_W-1:0]   rnd_q;
  logic [CNT_W-1:0]   byte_cnt_q;

  logic [BLOCK_W-1:0] ark_c;
  logic [BLOCK_W-1:0] shf_c;
  logic [BLOCK_W-1:0] sub_c;
  logic [BLOCK_W-1:0] mc_c;
  logic               abort_c;

  // GF(2^8) multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as AES requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = a;
    res = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8)
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] x;
    x = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(x);
  endfunction

  // One column of InvMixColumns; byte j of the column is row j
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[7:0];
    a1 = col[15:8];
    a2 = col[23:16];
    a3 = col[31:24];
    return {gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09)};
  endfunction

`ifdef AES_DEC_ABORT_EN
  assign abort_c = ctrl_abort_dec && (state_q != IDLE);
`else
  assign abort_c = 1'b0;
`endif

  assign ark_c = blk_q ^ dec_key;

  // InvShiftRows: row r rotates right by r, so out[r][c] = in[r][(c-r) mod 4]
  always_comb begin
    shf_c = blk_q;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shf_c[BYTE_W*(4*c+r) +: BYTE_W] = blk_q[BYTE_W*(4*((c-r+4)%4)+r) +: BYTE_W];
      end
    end
  end

  // InvSubBytes on the single byte picked by the byte counter
  always_comb begin
    sub_c = blk_q;
    sub_c[{byte_cnt_q, 3'b000} +: BYTE_W] = inv_sbox(blk_q[{byte_cnt_q, 3'b000} +: BYTE_W]);
  end

  // InvMixColumns on all four columns
  always_comb begin
    mc_c = blk_q;
    for (int c = 0; c < NCOLS; c++) begin
      mc_c[COL_W*c +: COL_W] = inv_mix_col(blk_q[COL_W*c +: COL_W]);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (ctrl_dataIn_dec) state_d = ADDRK;
      ADDRK: begin
        if (rnd_q == RND_LAST)       state_d = DONE;
        else if (rnd_q == RND_FIRST) state_d = INVSHF;
        else                         state_d = INVMC;
      end
      INVSHF: state_d = INVSUB;
      INVSUB: if (byte_cnt_q == CNT_LAST) state_d = ADDRK;
      INVMC:  state_d = INVSHF;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_c) state_d = IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath, round/byte counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_q            <= '0;
      rnd_q            <= '0;
      byte_cnt_q       <= '0;
      dec_keyAddr      <= '0;
      dec_dataOut      <= '0;
      ctrl_dataOut_dec <= 1'b0;
      dec_busy         <= 1'b0;
    end else begin
      ctrl_dataOut_dec <= 1'b0;
      dec_busy         <= (state_d != IDLE);
      if (abort_c) begin
        // clear the byte counter so the next block starts at byte 0
        dec_keyAddr <= '0;
        byte_cnt_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (ctrl_dataIn_dec) begin
              blk_q       <= dec_dataIn;
              rnd_q       <= RND_FIRST;
              dec_keyAddr <= RND_FIRST;
            end
          end
          ADDRK: begin
            blk_q <= ark_c;
            if (rnd_q == RND_FIRST) begin
              rnd_q       <= RND_NEXT;
              dec_keyAddr <= RND_NEXT;
            end
          end
          INVSHF: blk_q <= shf_c;
          INVSUB: begin
            blk_q      <= sub_c;
            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
          end
          INVMC: begin
            // key index moves early so it is settled long before ADDRK
            blk_q       <= mc_c;
            rnd_q       <= rnd_q - RND_W'(1);
            dec_keyAddr <= rnd_q - RND_W'(1);
          end
          DONE: begin
            dec_dataOut      <= blk_q;
            ctrl_dataOut_dec <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes256_dec_fsm.sv
// Testbench for aes256_dec_fsm. Expected plaintexts come from a forward AES-256
// model (ciphertext = encrypt(random plaintext)) plus the FIPS-197 C.3 vector.
module tb_aes256_dec_fsm;

  localparam int unsigned NVEC     = 6;
  localparam int          LATENCY  = 267;
  localparam int          MAX_WAIT = 300;

  localparam logic [127:0] FIPS_CT = 128'h8960494b9049fceabf456751cab7a28e;
  localparam logic [127:0] FIPS_PT = 128'hffeeddccbbaa99887766554433221100;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] dec_dataIn;
  logic         ctrl_dataIn_dec;
  logic [127:0] dec_key;
  logic [3:0]   dec_keyAddr;
  logic [127:0] dec_dataOut;
  logic         ctrl_dataOut_dec;
  logic         dec_busy;
`ifdef AES_DEC_ABORT_EN
  logic         ctrl_abort_dec;
`endif

  aes256_dec_fsm dut (
    .clk              (clk),
    .reset            (reset),
    .dec_dataIn       (dec_dataIn),
    .ctrl_dataIn_dec  (ctrl_dataIn_dec),
`ifdef AES_DEC_ABORT_EN
    .ctrl_abort_dec   (ctrl_abort_dec),
`endif
    .dec_key          (dec_key),
    .dec_keyAddr      (dec_keyAddr),
    .dec_dataOut      (dec_dataOut),
    .ctrl_dataOut_dec (ctrl_dataOut_dec),
    .dec_busy         (dec_busy)
  );

  always #5 clk = ~clk;

  logic [7:0]   sb [256];
  logic [127:0] rk [16];

  assign dec_key = rk[dec_keyAddr];

  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
  } vec_t;

  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box from its definition: brute-force inverse, then affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  // AES-256 key schedule for key 00 01 .. 1f, packed little-endian per round
  task automatic expand_key();
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int r = 0; r < 15; r++)
      for (int k = 0; k < 16; k++)
        rk[r][8*k +: 8] = w[4*r + k/4][8*(3 - k%4) +: 8];
    rk[15] = '0;
  endtask

  // Forward AES-256 cipher
  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] blk;
    blk = pt ^ rk[0];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int k = 0; k < 16; k++) s[k] = sb[blk[8*k +: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
        if (rnd != 14) begin
          s[4*c+0] = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      for (int k = 0; k < 16; k++) blk[8*k +: 8] = s[k];
      blk = blk ^ rk[rnd];
    end
    return blk;
  endfunction

  // Start one block and watch MAX_WAIT edges: pulses, result, key index walk
  task automatic run_op(input logic [127:0] ct, input int inject_at, input logic [127:0] inject_ct,
                        output int first_pulse, output int npulses, output logic [127:0] result,
                        output int key_steps, output int key_err);
    int prev;
    dec_dataIn      = ct;
    ctrl_dataIn_dec = 1'b1;
    tick();
    ctrl_dataIn_dec = 1'b0;
    first_pulse = 0;
    npulses     = 0;
    result      = '0;
    key_steps   = 0;
    key_err     = (dec_keyAddr != 4'd14) ? 1 : 0;
    prev        = int'(dec_keyAddr);
    for (int e = 1; e <= MAX_WAIT; e++) begin
      if (e == inject_at) begin
        dec_dataIn      = inject_ct;
        ctrl_dataIn_dec = 1'b1;
      end
      tick();
      ctrl_dataIn_dec = 1'b0;
      if (int'(dec_keyAddr) != prev) begin
        if (int'(dec_keyAddr) == prev - 1) key_steps++;
        else key_err++;
        prev = int'(dec_keyAddr);
      end
      if (ctrl_dataOut_dec) begin
        npulses++;
        if (first_pulse == 0) begin
          first_pulse = e;
          result      = dec_dataOut;
        end
      end
    end
  endtask

  // Edges until the next pulse (-1 if none within MAX_WAIT)
  task automatic wait_pulse(output int edges, output logic [127:0] res);
    edges = -1;
    res   = '0;
    for (int e = 1; e <= MAX_WAIT; e++) begin
      tick();
      if (ctrl_dataOut_dec) begin
        edges = e;
        res   = dec_dataOut;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int           fp, np, ks, ke, edges, pulses;
    logic [127:0] res;
    logic [127:0] last_pt;

    reset           = 1'b1;
    dec_dataIn      = '0;
    ctrl_dataIn_dec = 1'b0;
`ifdef AES_DEC_ABORT_EN
    ctrl_abort_dec  = 1'b0;
`endif
    build_sbox();
    expand_key();

    vecs[0] = '{ct: FIPS_CT, pt: FIPS_PT, lat: LATENCY};
    vecs[1] = '{ct: aes_enc('0), pt: '0, lat: LATENCY};
    vecs[2] = '{ct: aes_enc('1), pt: '1, lat: LATENCY};
    for (int i = 3; i < NVEC; i++) begin
      vecs[i].pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      vecs[i].ct  = aes_enc(vecs[i].pt);
      vecs[i].lat = LATENCY;
    end

    // Reset state
    tick();
    tick();
    chk("reset_keyaddr", 128'(dec_keyAddr), '0);
    chk("reset_dataout", dec_dataOut, '0);
    chk("reset_pulse", 128'(ctrl_dataOut_dec), '0);
    chk("reset_busy", 128'(dec_busy), '0);
    reset = 1'b0;
    tick();

    chk("model_fips_encrypt", aes_enc(FIPS_PT), FIPS_CT);

    // Vector table
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].ct, 0, '0, fp, np, res, ks, ke);
      chk($sformatf("vec%0d_result", i), res, vecs[i].pt);
      chk_int($sformatf("vec%0d_latency", i), fp, vecs[i].lat);
      chk_int($sformatf("vec%0d_pulses", i), np, 1);
      chk_int($sformatf("vec%0d_key_steps", i), ks, 14);
      chk_int($sformatf("vec%0d_key_err", i), ke, 0);
      chk($sformatf("vec%0d_hold", i), dec_dataOut, vecs[i].pt);
    end

    // Start request while busy is ignored
    run_op(vecs[0].ct, 100, vecs[3].ct, fp, np, res, ks, ke);
    chk("busy_ignore_result", res, FIPS_PT);
    chk_int("busy_ignore_pulses", np, 1);
    chk_int("busy_ignore_latency", fp, LATENCY);

    // Back-to-back: second start in the IDLE cycle right after DONE
    dec_dataIn      = vecs[3].ct;
    ctrl_dataIn_dec = 1'b1;
    tick();
    ctrl_dataIn_dec = 1'b0;
    wait_pulse(edges, res);
    chk_int("b2b_first_latency", edges, LATENCY);
    chk("b2b_first_result", res, vecs[3].pt);
    chk("b2b_idle_busy", 128'(dec_busy), '0);
    dec_dataIn      = vecs[4].ct;
    ctrl_dataIn_dec = 1'b1;
    tick();
    ctrl_dataIn_dec = 1'b0;
    chk("b2b_accept_busy", 128'(dec_busy), 128'(1));
    wait_pulse(edges, res);
    chk_int("b2b_pulse_gap", (edges < 0) ? -1 : edges + 1, LATENCY + 1);
    chk("b2b_second_result", res, vecs[4].pt);

    // Reset mid-operation at edge 150
    dec_dataIn      = vecs[5].ct;
    ctrl_dataIn_dec = 1'b1;
    tick();
    ctrl_dataIn_dec = 1'b0;
    repeat (149) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_keyaddr", 128'(dec_keyAddr), '0);
    chk("midreset_dataout", dec_dataOut, '0);
    chk("midreset_pulse", 128'(ctrl_dataOut_dec), '0);
    chk("midreset_busy", 128'(dec_busy), '0);
    pulses = 0;
    repeat (MAX_WAIT) begin
      tick();
      if (ctrl_dataOut_dec) pulses++;
    end
    chk_int("midreset_no_pulse", pulses, 0);
    run_op(vecs[5].ct, 0, '0, fp, np, res, ks, ke);
    chk("after_reset_result", res, vecs[5].pt);
    chk_int("after_reset_latency", fp, LATENCY);
    last_pt = vecs[5].pt;

    // Reset wins over a simultaneous start
    reset           = 1'b1;
    ctrl_dataIn_dec = 1'b1;
    dec_dataIn      = vecs[1].ct;
    tick();
    reset           = 1'b0;
    ctrl_dataIn_dec = 1'b0;
    chk("reset_prio_busy", 128'(dec_busy), '0);
    chk("reset_prio_keyaddr", 128'(dec_keyAddr), '0);
    tick();
    chk("reset_prio_stays_idle", 128'(dec_busy), '0);
    run_op(vecs[2].ct, 0, '0, fp, np, res, ks, ke);
    chk("post_prio_result", res, vecs[2].pt);
    last_pt = vecs[2].pt;

`ifdef AES_DEC_ABORT_EN
    // Abort at edge 50: back to IDLE, no pulse, output unchanged
    dec_dataIn      = vecs[3].ct;
    ctrl_dataIn_dec = 1'b1;
    tick();
    ctrl_dataIn_dec = 1'b0;
    repeat (49) tick();
    ctrl_abort_dec = 1'b1;
    tick();
    ctrl_abort_dec = 1'b0;
    chk("abort_busy", 128'(dec_busy), '0);
    chk("abort_keyaddr", 128'(dec_keyAddr), '0);
    chk("abort_dataout", dec_dataOut, last_pt);
    pulses = 0;
    repeat (MAX_WAIT) begin
      tick();
      if (ctrl_dataOut_dec) pulses++;
    end
    chk_int("abort_no_pulse", pulses, 0);
    run_op(vecs[4].ct, 0, '0, fp, np, res, ks, ke);
    chk("after_abort_result", res, vecs[4].pt);
    chk_int("after_abort_latency", fp, LATENCY);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
